// File: rtl/pb_event_decoder.sv
// pb_event_decoder: classifies debounced push-button presses into short,
// long and double presses and emits auto-repeat ticks while a long press is held.
// Optional feature: define PB_EVENT_DOUBLE_EN to build double-press detection
// (GAP/PRESS2 states). When it is undefined, short_tick fires on release and
// double_tick is tied low.
module pb_event_decoder #(
  parameter int unsigned LONG_CYCLES       = 50_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000,
  parameter int unsigned CNT_W             = 26
) (
  input  logic clk,
  input  logic resetn,
  input  logic pb_level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic repeat_tick,
  output logic hold
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef PB_EVENT_DOUBLE_EN
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HELD   = 3'd2
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Press classifier: state, shared counter and registered one-cycle ticks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      repeat_tick <= 1'b0;
      hold        <= 1'b0;
    end else begin
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      repeat_tick <= 1'b0;
      hold        <= 1'b0;
      case (state)
        IDLE: begin
          if (pb_level) begin
            state <= PRESS;
            cnt   <= '0;
          end
        end
        PRESS: begin
          // Release wins over the long threshold on the same edge.
          if (!pb_level) begin
`ifdef PB_EVENT_DOUBLE_EN
            state <= GAP;
`else
            state      <= IDLE;
            short_tick <= 1'b1;
`endif
            cnt <= '0;
          end else if (cnt == LONG_LAST) begin
            state     <= HELD;
            long_tick <= 1'b1;
            hold      <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!pb_level) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            hold <= 1'b1;
            if (cnt == REPEAT_LAST) begin
              repeat_tick <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
`ifdef PB_EVENT_DOUBLE_EN
        GAP: begin
          // A new press wins over the gap timeout on the same edge.
          if (pb_level) begin
            state       <= PRESS2;
            double_tick <= 1'b1;
            cnt         <= '0;
          end else if (cnt == GAP_LAST) begin
            state      <= IDLE;
            short_tick <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESS2: begin
          // Second press of a double is not classified further.
          if (!pb_level) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pb_event_decoder.md
# pb_event_decoder

Consumes the debounced push-button level produced by the button debouncer and classifies each press as a short press, long press, or double press. While a long press is held, it also generates periodic auto-repeat ticks. It sits between the debouncer and the GPIO/interrupt register block, which latch its single-cycle ticks as button events for the Cortex-M0.

## Interface
- LONG_CYCLES, 50_000_000, high samples needed before a long press is declared (≥2)
- DOUBLE_GAP_CYCLES, 12_500_000, maximum low gap between the two presses of a double press (≥2)
- REPEAT_CYCLES, 10_000_000, auto-repeat period while held (≥2)
- CNT_W, 26, counter width; every *_CYCLES value must be < 2^CNT_W
- clk  input  1  system clock; all state changes on the rising edge
- resetn  input  1  reset, asynchronous, active-low
- pb_level  input  1  debounced button level, 1 = pressed, already synchronous to clk
- short_tick  output  1  one-cycle pulse: short press
- long_tick  output  1  one-cycle pulse: long-press threshold reached
- double_tick  output  1  one-cycle pulse: second press of a double press
- repeat_tick  output  1  one-cycle pulse: auto-repeat while held
- hold  output  1  level; high while in HELD

## Operation
- Reset:
  - state = IDLE, cnt = 0.
  - All outputs 0 immediately and for as long as resetn is low.
  - Asserting reset mid-sequence discards the sequence; no tick is emitted.
- All outputs are registered. A tick is high during the single cycle following the edge that decides it.
- Single counter cnt (CNT_W bits). It is cleared on every state change, and no state lets it wrap.
- States and transitions. "Edge" means the rising edge at which pb_level is sampled.
  - IDLE:
    - pb_level=1 → PRESS.
    - This includes pb_level=1 on the first edge after reset release.
  - PRESS:
    - pb_level=0 → GAP (macro defined) or IDLE with short_tick (macro undefined).
    - Otherwise, if cnt==LONG_CYCLES-1 → HELD with long_tick.
    - Otherwise cnt++.
    - Release takes priority over the long threshold.
  - HELD:
    - pb_level=0 → IDLE, no tick.
    - Otherwise, if cnt==REPEAT_CYCLES-1 → repeat_tick and cnt=0.
    - Otherwise cnt++.
  - GAP:
    - pb_level=1 → PRESS2 with double_tick.
    - Otherwise, if cnt==DOUBLE_GAP_CYCLES-1 → IDLE with short_tick.
    - Otherwise cnt++.
    - Press takes priority over the timeout.
  - PRESS2:
    - pb_level=0 → IDLE.
    - No long, repeat or short detection in this state.
- hold = (state==HELD), registered.
- At most one tick is high in any cycle.

## Timing
- Press sampled high first at edge k, and high at edges k..k+LONG_CYCLES:
  - long_tick and hold rise after edge k+LONG_CYCLES.
  - repeat_tick follows after k+LONG_CYCLES+n·REPEAT_CYCLES for each n≥1 while still held.
- Release sampled at edge r with fewer than LONG_CYCLES+1 high samples:
  - Macro undefined: short_tick after edge r.
  - Macro defined: high at any edge r+1..r+DOUBLE_GAP_CYCLES gives double_tick after that edge; otherwise short_tick after edge r+DOUBLE_GAP_CYCLES.
- hold falls after the first edge at which pb_level=0 is sampled in HELD.

## Configuration
- PB_EVENT_DOUBLE_EN defined:
  - GAP and PRESS2 exist; double press is detected.
  - short_tick is delayed by DOUBLE_GAP_CYCLES.
- Undefined:
  - GAP and PRESS2 are not built; double_tick is tied to 0.
  - short_tick is emitted on the release edge.

## Test plan
All scenarios use LONG_CYCLES=8, DOUBLE_GAP_CYCLES=4, REPEAT_CYCLES=3, CNT_W=4.
- Short press: high at edges k..k+2, low from k+3 → short_tick once after edge k+7 (macro defined) or after edge k+3 (undefined); no other tick.
- Long hold: high at edges k..k+19, low at k+20 → long_tick after k+8; repeat_tick after k+11, k+14, k+17; hold high after edges k+8..k+19, low after k+20; no short_tick.
- Double press (macro defined): high at k,k+1; low at k+2,k+3; high from k+4 → double_tick after k+4, no short_tick; holding 20 more cycles gives no long_tick; release returns to IDLE.
- Gap boundary (macro defined): release at r, high at r+4 → double_tick; release at r, high at r+5 → short_tick after r+4, then a new PRESS starts at r+5.
- Reset mid-HELD: drop resetn while hold=1 → all outputs 0 immediately; release reset with pb_level=1 → long_tick after 8 further edges; nothing before.
- Macro undefined: repeat the double-press stimulus → two short_ticks (after k+2 and after the second release), double_tick stays 0.
